// File: rtl/ques_four_if.sv
// Data, select and enable into the demux plus its four routed outputs and one-hot select.
interface ques_four_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] A;
    logic             SA;
    logic             SB;
    logic [WIDTH-1:0] Y0;
    logic [WIDTH-1:0] Y1;
    logic [WIDTH-1:0] Y2;
    logic [WIDTH-1:0] Y3;
    logic [3:0]       sel_oh;

    modport master (
        output en, A, SA, SB,
        input  Y0, Y1, Y2, Y3, sel_oh
    );

    modport slave (
        input  en, A, SA, SB,
        output Y0, Y1, Y2, Y3, sel_oh
    );
endinterface

// File: rtl/ques_four.sv
// Registered 1-to-4 demux steering A onto Y[{SA,SB}], all other outputs zeroed.
// One-cycle latency; en=0 holds every output (no backpressure path).
module ques_four #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    ques_four_if.slave  bus
);
    logic [3:0][WIDTH-1:0] y_q;
    logic [3:0][WIDTH-1:0] y_d;
    logic [3:0]            sel_oh_q;
    logic [3:0]            sel_oh_d;
    logic [1:0]            sel;

    assign sel = {bus.SA, bus.SB};

    always_comb begin
        y_d      = y_q;
        sel_oh_d = sel_oh_q;
        if (bus.en) begin
            // Whole vector cleared first so only the newly selected lane carries data.
            y_d      = '0;
            y_d[sel] = bus.A;
            sel_oh_d = 4'b0001 << sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            sel_oh_q <= 4'b0000;
        end else begin
            y_q      <= y_d;
            sel_oh_q <= sel_oh_d;
        end
    end

    assign bus.Y0     = y_q[0];
    assign bus.Y1     = y_q[1];
    assign bus.Y2     = y_q[2];
    assign bus.Y3     = y_q[3];
    assign bus.sel_oh = sel_oh_q;
endmodule

// File: tb/tb_ques_four.sv
// Randomized and directed check of ques_four at WIDTH=1 and WIDTH=8 against a routing model.
module tb_ques_four;
    logic clk;
    logic rst_n;

    ques_four_if #(.WIDTH(1)) if1 ();
    ques_four_if #(.WIDTH(8)) if8 ();

    ques_four #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    ques_four #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: what each output should show, per instance.
    logic [7:0] m1_y [4];
    logic [3:0] m1_oh;
    logic [7:0] m8_y [4];
    logic [3:0] m8_oh;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m1_y[n] = 8'h00;
            m8_y[n] = 8'h00;
        end
        m1_oh = 4'b0000;
        m8_oh = 4'b0000;
    endtask

    // An enabled edge puts A on the selected lane and zero everywhere else.
    task automatic model_edge();
        int s1, s8;
        s1 = {if1.SA, if1.SB};
        s8 = {if8.SA, if8.SB};
        if (if1.en) begin
            for (int n = 0; n < 4; n++) m1_y[n] = (n == s1) ? {7'b0, if1.A} : 8'h00;
            m1_oh = 4'(1 << s1);
        end
        if (if8.en) begin
            for (int n = 0; n < 4; n++) m8_y[n] = (n == s8) ? if8.A : 8'h00;
            m8_oh = 4'(1 << s8);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".w1.Y0"}, if1.Y0, m1_y[0]);
        chk({tag, ".w1.Y1"}, if1.Y1, m1_y[1]);
        chk({tag, ".w1.Y2"}, if1.Y2, m1_y[2]);
        chk({tag, ".w1.Y3"}, if1.Y3, m1_y[3]);
        chk({tag, ".w1.oh"}, if1.sel_oh, m1_oh);
        chk({tag, ".w8.Y0"}, if8.Y0, m8_y[0]);
        chk({tag, ".w8.Y1"}, if8.Y1, m8_y[1]);
        chk({tag, ".w8.Y2"}, if8.Y2, m8_y[2]);
        chk({tag, ".w8.Y3"}, if8.Y3, m8_y[3]);
        chk({tag, ".w8.oh"}, if8.sel_oh, m8_oh);
    endtask

    task automatic drive(input logic en1, input logic a1, input logic [1:0] s1,
                         input logic en8, input logic [7:0] a8, input logic [1:0] s8);
        if1.en = en1; if1.A = a1; {if1.SA, if1.SB} = s1;
        if8.en = en8; if8.A = a8; {if8.SA, if8.SB} = s8;
    endtask

    // Drive on the falling edge, let the rising edge update, sample 1 time unit later.
    task automatic step(input string tag,
                        input logic en1, input logic a1, input logic [1:0] s1,
                        input logic en8, input logic [7:0] a8, input logic [1:0] s8);
        @(negedge clk);
        drive(en1, a1, s1, en8, a8, s8);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 2'b11, 1'b1, 8'hFF, 2'b11);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");

        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step("truth", 1'b1, v[0], v[2:1], 1'b1, 8'($urandom), v[2:1]);
            if (v[0]) begin
                case (v[2:1])
                    2'b00: chk("truth.Y0_one", if1.Y0, 1);
                    2'b01: chk("truth.Y1_one", if1.Y1, 1);
                    2'b10: chk("truth.Y2_one", if1.Y2, 1);
                    default: chk("truth.Y3_one", if1.Y3, 1);
                endcase
            end
        end

        step("hold_load", 1'b1, 1'b1, 2'b10, 1'b1, 8'h3C, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 2'b00);
            chk("hold.Y2", if1.Y2, 1);
            chk("hold.oh", if1.sel_oh, 4'b0100);
        end

        // Inputs changed mid-cycle must not reach the outputs before the edge.
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b01, 1'b1, 8'h81, 2'b11);
        #2;
        check_all("latency_pre");
        @(posedge clk);
        model_edge();
        #1;
        check_all("latency_post");

        step("w8_a5", 1'b1, 1'b0, 2'b00, 1'b1, 8'hA5, 2'b01);
        chk("w8.Y1_a5", if8.Y1, 8'hA5);
        chk("w8.oh_0010", if8.sel_oh, 4'b0010);

        for (int i = 0; i < 40; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                 1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom));
        end

        step("zero_data", 1'b1, 1'b0, 2'b11, 1'b1, 8'h00, 2'b10);

        step("pre_async", 1'b1, 1'b1, 2'b11, 1'b1, 8'h5A, 2'b11);
        chk("pre_async.Y3", if1.Y3, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst.Y3", if1.Y3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 1'b1, 2'b00, 1'b1, 8'h77, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
